x_muldiv_seq: RTL and testbench



---
 rtl/x_muldiv_seq.sv | 139 +++++++++++++
 tb/tb_x_muldiv_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/x_muldiv_seq.sv
// rtl/x_muldiv_seq.sv - iterative unsigned MUL/MULHU/DIVU/REMU sequencer, one bit per cycle
// Stalls the X stage while an operation is in flight and returns a registered result.
module x_muldiv_seq #(
  parameter int N_BITS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [N_BITS-1:0] op1,
  input  logic [N_BITS-1:0] op2,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [N_BITS-1:0] result,
  output logic              x_stall
);

  localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [N_BITS-1:0]   a_q, a_d;
  logic [N_BITS-1:0]   b_q, b_d;
  logic [N_BITS-1:0]   rem_q, rem_d;
  logic [N_BITS-1:0]   result_q, result_d;
  logic [2*N_BITS-1:0] acc_q, acc_d;

  logic                accept;
  logic                div_zero;
  logic                last;
  logic [N_BITS:0]     psum;
  logic [N_BITS:0]     trial;
  logic [N_BITS:0]     diff;

  assign accept   = (state_q == S_IDLE) && req_valid && !flush;
  assign div_zero = req_op[1] && (op2 == '0);
  assign last     = (cnt_q == CW'(N_BITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid) state_d = div_zero ? S_DONE : S_RUN;
        S_RUN:  if (last) state_d = S_DONE;
        S_DONE: if (resp_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_DONE);
    x_stall    = ((state_q == S_IDLE) && req_valid && !flush) ||
                 (state_q == S_RUN) ||
                 ((state_q == S_DONE) && !resp_ready);
  end

  // Multiply keeps the multiplier in the low half of acc and shifts it out LSB first;
  // divide shifts the dividend out of a_q MSB first while quotient bits shift in.
  always_comb begin
    psum     = {1'b0, acc_q[2*N_BITS-1:N_BITS]} + {1'b0, (acc_q[0] ? a_q : {N_BITS{1'b0}})};
    trial    = {rem_q, a_q[N_BITS-1]};
    diff     = trial - {1'b0, b_q};
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (accept) begin
      op_d  = req_op;
      a_d   = op1;
      b_d   = op2;
      rem_d = '0;
      acc_d = {{N_BITS{1'b0}}, op2};
      cnt_d = '0;
      if (div_zero) result_d = req_op[0] ? op1 : {N_BITS{1'b1}};
    end else if (state_q == S_RUN) begin
      cnt_d = cnt_q + CW'(1);
      if (!op_q[1]) begin
        acc_d = {psum, acc_q[N_BITS-1:1]};
      end else if (!diff[N_BITS]) begin
        rem_d = diff[N_BITS-1:0];
        a_d   = {a_q[N_BITS-2:0], 1'b1};
      end else begin
        rem_d = trial[N_BITS-1:0];
        a_d   = {a_q[N_BITS-2:0], 1'b0};
      end
      if (last && !flush) begin
        case (op_q)
          2'b00:   result_d = acc_d[N_BITS-1:0];
          2'b01:   result_d = acc_d[2*N_BITS-1:N_BITS];
          2'b10:   result_d = a_d;
          default: result_d = rem_d;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_x_muldiv_seq.sv
// tb/tb_x_muldiv_seq.sv - directed bench for x_muldiv_seq with an arithmetic reference model
// A per-cycle expectation timeline is checked on every falling edge.
module tb_x_muldiv_seq;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic [1:0]   req_op = 2'b00;
  logic [N-1:0] op1 = '0;
  logic [N-1:0] op2 = '0;
  logic         flush = 1'b0;
  logic         resp_ready = 1'b1;
  logic         req_ready;
  logic         resp_valid;
  logic [N-1:0] result;
  logic         x_stall;

  x_muldiv_seq #(.N_BITS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .op1        (op1),
    .op2        (op2),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .result     (result),
    .x_stall    (x_stall)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic         chk_en = 1'b0;
  logic         e_ready = 1'b1;
  logic         e_valid = 1'b0;
  logic         e_stall = 1'b0;
  logic [N-1:0] e_res = '0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("resp_valid", 32'(resp_valid), 32'(e_valid));
      check("x_stall", 32'(x_stall), 32'(e_stall));
      check("result", result, e_res);
    end
  end

  function automatic logic [N-1:0] model(input logic [1:0] op, input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    logic [2*N-1:0] p;
    p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    case (op)
      2'b00:   return p[N-1:0];
      2'b01:   return p[2*N-1:N];
      2'b10:   return (b == '0) ? {N{1'b1}} : a / b;
      default: return (b == '0) ? a : a % b;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic r, input logic v, input logic s);
    e_ready = r;
    e_valid = v;
    e_stall = s;
  endtask

  // Cycle 0 is the accept cycle; the response appears at cycle lat and is held for hold extra cycles.
  task automatic run_op(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] lit, input int hold);
    int lat;
    lat = (op[1] && b == '0) ? 1 : N + 1;
    req_valid  = 1'b1;
    req_op     = op;
    op1        = a;
    op2        = b;
    resp_ready = (hold == 0);
    set_exp(1'b1, 1'b0, 1'b1);
    step();
    req_valid = 1'b0;
    op1       = $urandom;
    op2       = $urandom;
    req_op    = 2'($urandom);
    for (int c = 1; c < lat; c++) begin
      set_exp(1'b0, 1'b0, 1'b1);
      step();
    end
    e_res = model(op, a, b);
    for (int h = 0; h <= hold; h++) begin
      resp_ready = (h == hold);
      set_exp(1'b0, 1'b1, !resp_ready);
      if (h == 0) begin
        @(negedge clk);
        check("literal", result, lit);
      end
      step();
    end
    set_exp(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    set_exp(1'b1, 1'b0, 1'b0);
    e_res  = '0;
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    step();

    run_op(2'b00, 32'd7, 32'd6, 32'd42, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op(2'b10, 32'd100, 32'd7, 32'd14, 0);
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 0);
    run_op(2'b10, 32'h8000_0000, 32'd1, 32'h8000_0000, 0);
    run_op(2'b11, 32'd5, 32'd9, 32'd5, 0);
    run_op(2'b10, 32'd123, 32'd0, 32'hFFFF_FFFF, 0);
    run_op(2'b11, 32'd123, 32'd0, 32'd123, 0);
    run_op(2'b00, 32'd3, 32'd5, 32'd15, 3);
    step();

    // Flush in RUN with cnt at 10 (cycle 11 after accept).
    req_valid = 1'b1;
    req_op    = 2'b00;
    op1       = 32'd11;
    op2       = 32'd13;
    set_exp(1'b1, 1'b0, 1'b1);
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      set_exp(1'b0, 1'b0, 1'b1);
      step();
    end
    flush = 1'b1;
    set_exp(1'b0, 1'b0, 1'b1);
    step();
    flush = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0);
    step();
    step();
    run_op(2'b10, 32'd9, 32'd3, 32'd3, 0);

    // Flush coincident with a request in IDLE must not accept it.
    req_valid = 1'b1;
    flush     = 1'b1;
    req_op    = 2'b10;
    op1       = 32'd50;
    op2       = 32'd0;
    set_exp(1'b1, 1'b0, 1'b0);
    step();
    req_valid = 1'b0;
    flush     = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0);
    step();
    step();

    // Reset in the middle of RUN.
    req_valid = 1'b1;
    req_op    = 2'b00;
    op1       = 32'd9;
    op2       = 32'd9;
    set_exp(1'b1, 1'b0, 1'b1);
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      set_exp(1'b0, 1'b0, 1'b1);
      step();
    end
    rst = 1'b1;
    set_exp(1'b0, 1'b0, 1'b1);
    step();
    rst   = 1'b0;
    e_res = '0;
    set_exp(1'b1, 1'b0, 1'b0);
    step();
    run_op(2'b00, 32'd2, 32'd2, 32'd4, 0);
    step();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
